snoop_resp_collector: RTL
=========================

SNOOP_RESP_COLLECTOR -- requirements
Module: snoop_resp_collector

Interface
REQ-001 SHALL have parameter snoop_req_t, default logic: snoop request bundle type (ac_valid, ac, cr_ready, cd_ready).
REQ-002 SHALL have parameter snoop_resp_t, default logic: snoop response bundle type (ac_ready, cr_valid, cr_resp, cd_valid, cd).
REQ-003 SHALL have parameters ac_chan_t, cr_chan_t, cd_chan_t, default logic: AC, CR and CD channel types; cd_chan_t has fields data and last.
REQ-004 SHALL have parameter CdBeats, default 4: CD beats per cache line, at least 2.
REQ-005 SHALL have parameter CdDataWidth, default 64: width of cd.data.
REQ-006 SHALL have port clk_i, input, 1: clock; all state on the rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid_i / req_ready_o, input / output, 1 each: snoop command handshake.
REQ-009 SHALL have port req_ac_i, input, ac_chan_t: snoop command payload.
REQ-010 SHALL have port snoop_req_o, output, snoop_req_t: drives one slave port of the snoop multiplexer.
REQ-011 SHALL have port snoop_resp_i, input, snoop_resp_t: response from that same slave port.
REQ-012 SHALL have port rsp_valid_o / rsp_ready_i, output / input, 1 each: result handshake.
REQ-013 SHALL have port rsp_cr_o, output, cr_chan_t: latched CRRESP.
REQ-014 SHALL have port rsp_data_o, output, CdBeats*CdDataWidth: collected line; beat k occupies bits [k*CdDataWidth +: CdDataWidth].
REQ-015 SHALL have port rsp_err_o, output, 1: CD framing error flag.

Function
REQ-016 SHALL implement FSM states IDLE, AC, CR, CD, RESP; reset state IDLE.
REQ-017 IDLE: req_ready_o = 1; on req_valid_i & req_ready_o, latch req_ac_i, clear data buffer and error, go to AC.
REQ-018 AC: ac_valid = 1 with the latched payload held stable; on ac_ready, go to CR. ac_valid SHALL NOT be deasserted before the handshake.
REQ-019 CR: cr_ready = 1; on cr_valid, latch cr_resp. Go to CD if cr_resp[0] (DataTransfer) = 1, otherwise go to RESP.
REQ-020 CD: cd_ready = 1; each accepted beat is written to buffer slot beat_cnt, and beat_cnt increments; the transition to RESP occurs on the beat accepted at beat_cnt = CdBeats-1.
REQ-021 beat_cnt SHALL be $clog2(CdBeats) bits wide, SHALL be zeroed on entry to CD, and SHALL NOT wrap within a transaction.
REQ-022 cr_ready SHALL be 0 outside CR; cd_ready SHALL be 0 outside CD; a CD beat presented during CR SHALL wait.
REQ-023 RESP: rsp_valid_o = 1, with rsp_cr_o, rsp_data_o and rsp_err_o stable; on rsp_ready_i, go to IDLE.
REQ-024 Slots not written (no DataTransfer) SHALL read as 0.
REQ-025 req_ready_o SHALL be 0 in every state except IDLE; one transaction is outstanding at most.
REQ-026 Minimum latency without data: req handshake at t0, ac_valid at t1, CR accepted at t2 (same-cycle valid), rsp_valid_o at t3.
REQ-027 Minimum latency with data: rsp_valid_o SHALL assert at t3+CdBeats.
REQ-028 All handshake outputs SHALL be decoded from the registered state only, with no combinational path from any input valid to any output ready.

Reset
REQ-029 While rst_ni = 0, the block SHALL hold these values: state IDLE, req_ready_o = 1, ac_valid = 0, cr_ready = 0, cd_ready = 0, rsp_valid_o = 0, rsp_cr_o = 0, rsp_data_o = 0, rsp_err_o = 0, beat_cnt = 0.
REQ-030 A reset asserted mid-transaction SHALL abort the transaction immediately; no partial result SHALL be emitted after release.

Configuration
REQ-031 Macro SNOOP_COLLECTOR_LAST_CHECK_EN, when defined, SHALL set rsp_err_o (sticky until IDLE) in either of two cases: cd.last = 1 on a beat with beat_cnt < CdBeats-1, or cd.last = 0 on beat CdBeats-1. Beat counting SHALL be unaffected.
REQ-032 When SNOOP_COLLECTOR_LAST_CHECK_EN is undefined, cd.last SHALL be ignored, rsp_err_o SHALL be tied 0, and no check logic SHALL be synthesized.

Verification
REQ-033 No data: req ac.addr=0x80, ac_ready=1, cr_resp=5'b00000 -> rsp_valid_o at t3, rsp_cr_o=0, rsp_data_o=0.
REQ-034 Data: cr_resp=5'b00001, 4 beats 0x11..,0x22..,0x33..,0x44.. (last on beat 3) -> rsp_valid_o at t7, data in slots 0..3 in order, rsp_err_o=0.
REQ-035 Backpressure: ac_ready low for 5 cycles, then cd_valid gapped 1-on/1-off -> ac payload stable, all 4 beats captured, req_ready_o=0 throughout.
REQ-036 Macro on: cd.last=1 on beat 1 -> collection continues to 4 beats, rsp_err_o=1; the next clean transaction gives rsp_err_o=0.
REQ-037 Reset asserted in CD after 2 beats -> all outputs take their REQ-029 values asynchronously; after release, a new request completes normally.
REQ-038 rsp_ready_i held 0 for 10 cycles -> outputs stable, req_ready_o=0; accepted on the cycle rsp_ready_i=1, req_ready_o=1 on the next cycle.

Source files
------------

// File: rtl/snoop_resp_collector.sv
// rtl/snoop_resp_collector.sv - snoop AC/CR/CD sequencer that collects one cache line per request (optional SNOOP_COLLECTOR_LAST_CHECK_EN: cd.last framing check)

// Default channel bundles. Integrators override the type parameters with their own structs,
// which must provide the same field names; cd.data must be CdDataWidth bits wide.
package snoop_resp_collector_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef logic [4:0] cr_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_chan_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

endpackage

module snoop_resp_collector #(
  parameter type         snoop_req_t  = snoop_resp_collector_pkg::snoop_req_t,
  parameter type         snoop_resp_t = snoop_resp_collector_pkg::snoop_resp_t,
  parameter type         ac_chan_t    = snoop_resp_collector_pkg::ac_chan_t,
  parameter type         cr_chan_t    = snoop_resp_collector_pkg::cr_chan_t,
  parameter type         cd_chan_t    = snoop_resp_collector_pkg::cd_chan_t,
  parameter int unsigned CdBeats      = 4,
  parameter int unsigned CdDataWidth  = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  ac_chan_t                       req_ac_i,
  output snoop_req_t                     snoop_req_o,
  input  snoop_resp_t                    snoop_resp_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output cr_chan_t                       rsp_cr_o,
  output logic [CdBeats*CdDataWidth-1:0] rsp_data_o,
  output logic                           rsp_err_o
);

  // A line always has at least two beats, so the counter is at least one bit wide.
  localparam int unsigned    BeatW    = (CdBeats > 2) ? $clog2(CdBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(CdBeats - 1);

  typedef enum logic [2:0] {
    IDLE,
    AC,
    CR,
    CD,
    RESP
  } state_e;

  state_e                           state_q;
  ac_chan_t                         ac_q;
  cr_chan_t                         cr_q;
  logic [CdBeats*CdDataWidth-1:0]   data_q;
  logic [BeatW-1:0]                 beat_cnt_q;

  // Handshake outputs live in flops next to the state, so no input valid reaches an output ready.
  logic req_ready_q;
  logic ac_valid_q;
  logic cr_ready_q;
  logic cd_ready_q;
  logic rsp_valid_q;

  // Transaction sequencer: command, snoop address, snoop response, optional line data, result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ac_q        <= '0;
      cr_q        <= '0;
      data_q      <= '0;
      beat_cnt_q  <= '0;
      req_ready_q <= 1'b1;
      ac_valid_q  <= 1'b0;
      cr_ready_q  <= 1'b0;
      cd_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_q) begin
            ac_q        <= req_ac_i;
            cr_q        <= '0;
            data_q      <= '0;
            beat_cnt_q  <= '0;
            req_ready_q <= 1'b0;
            ac_valid_q  <= 1'b1;
            state_q     <= AC;
          end
        end
        AC: begin
          // ac_valid stays up with ac_q untouched until the multiplexer takes it.
          if (snoop_resp_i.ac_ready) begin
            ac_valid_q <= 1'b0;
            cr_ready_q <= 1'b1;
            state_q    <= CR;
          end
        end
        CR: begin
          if (snoop_resp_i.cr_valid) begin
            cr_q       <= snoop_resp_i.cr_resp;
            cr_ready_q <= 1'b0;
            if (snoop_resp_i.cr_resp[0]) begin
              // DataTransfer: a full line follows on CD.
              beat_cnt_q <= '0;
              cd_ready_q <= 1'b1;
              state_q    <= CD;
            end else begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        CD: begin
          if (snoop_resp_i.cd_valid) begin
            for (int k = 0; k < int'(CdBeats); k++) begin
              if (beat_cnt_q == BeatW'(k)) begin
                data_q[k*CdDataWidth +: CdDataWidth] <= snoop_resp_i.cd.data;
              end
            end
            // The beat count alone ends collection; the counter never wraps inside a line.
            if (beat_cnt_q == LastBeat) begin
              cd_ready_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          ac_valid_q  <= 1'b0;
          cr_ready_q  <= 1'b0;
          cd_ready_q  <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Pack the registered handshakes and held AC payload into the multiplexer-facing bundle.
  always_comb begin
    snoop_req_o          = '0;
    snoop_req_o.ac_valid = ac_valid_q;
    snoop_req_o.ac       = ac_q;
    snoop_req_o.cr_ready = cr_ready_q;
    snoop_req_o.cd_ready = cd_ready_q;
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_cr_o    = cr_q;
  assign rsp_data_o  = data_q;

`ifdef SNOOP_COLLECTOR_LAST_CHECK_EN
  logic err_q;

  // Sticky framing error: last must be set on the final beat and only there; cleared by the next request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && req_valid_i && req_ready_q) begin
      err_q <= 1'b0;
    end else if (state_q == CD && snoop_resp_i.cd_valid &&
                 (snoop_resp_i.cd.last != (beat_cnt_q == LastBeat))) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err_o = err_q;
`else
  // Without the check, cd.last carries no meaning for this block.
  logic unused_cd_last;
  assign unused_cd_last = snoop_resp_i.cd.last;
  assign rsp_err_o      = 1'b0;
`endif

endmodule
